ecc_scrub_scheduler: RTL and testbench

ECC_SCRUB_SCHEDULER -- requirements
Module: ecc_scrub_scheduler

---
 rtl/ecc_scrub_pkg.sv | 15 +
 rtl/ecc_sat_counter.sv | 31 +++
 rtl/ecc_scrub_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_ecc_scrub_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ecc_scrub_pkg.sv
// Shared types and width constants for the ECC scrub scheduler slice.
package ecc_scrub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_TRIG  = 2'd2,
    ST_WAIT  = 2'd3
  } scrub_state_e;

  localparam int unsigned DefaultIntervalWidth = 16;
  localparam int unsigned DefaultCntWidth      = 16;
  localparam int unsigned DefaultTimeout       = 64;

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module ecc_sat_counter
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned Width = DefaultCntWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_r;

  // count register: clear wins, increment stops at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != {Width{1'b1}})) begin
      cnt_r <= cnt_r + Width'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ecc_scrub_scheduler.sv
// Paces scrub requests, tracks scrub address/passes, counts ECC errors.
// Optional macro ECC_SCRUB_ERR_ADDR_EN adds first-uncorrectable-address capture.
module ecc_scrub_scheduler
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned DataDepth     = 2048,
  parameter int unsigned IntervalWidth = DefaultIntervalWidth,
  parameter int unsigned CntWidth      = DefaultCntWidth,
  parameter int unsigned TimeoutCycles = DefaultTimeout,
  localparam int unsigned AddrWidth    = $clog2(DataDepth)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [IntervalWidth-1:0] interval_i,
  input  logic                     clear_i,
  output logic                     scrub_trigger_o,
  input  logic                     scrub_step_i,
  input  logic                     tag_corr_i,
  input  logic                     tag_unc_i,
  input  logic                     data_corr_i,
  input  logic                     data_unc_i,
  output logic [CntWidth-1:0]      tag_corr_cnt_o,
  output logic [CntWidth-1:0]      tag_unc_cnt_o,
  output logic [CntWidth-1:0]      data_corr_cnt_o,
  output logic [CntWidth-1:0]      data_unc_cnt_o,
  output logic [CntWidth-1:0]      pass_cnt_o,
  output logic                     pass_done_o,
  output logic [AddrWidth-1:0]     cur_addr_o,
  output logic                     stall_o,
  output logic                     irq_o
`ifdef ECC_SCRUB_ERR_ADDR_EN
  ,
  output logic [AddrWidth-1:0]     err_addr_o,
  output logic                     err_addr_valid_o
`endif
);

  localparam int unsigned WdWidth = $clog2(TimeoutCycles + 1);

  scrub_state_e           state_r, state_s;
  logic [IntervalWidth-1:0] icnt_r, icnt_s;
  logic [WdWidth-1:0]     wd_r, wd_s;
  logic                   timeout_s;
  scrub_state_e           resume_s;
  logic                   trig_r;
  logic [AddrWidth-1:0]   addr_r;
  logic                   wrap_s;
  logic                   pass_done_r;
  logic                   stall_r;
  logic                   irq_r;

  assign resume_s = enable_i ? ST_COUNT : ST_IDLE;

  // next-state, interval counter and watchdog
  always_comb begin
    state_s   = state_r;
    icnt_s    = icnt_r;
    wd_s      = wd_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        icnt_s = '0;
        if (enable_i) begin
          state_s = ST_COUNT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!enable_i) begin
          state_s = ST_IDLE;
          icnt_s  = '0;
        end else if (icnt_r == interval_i) begin
          state_s = ST_TRIG;
          icnt_s  = '0;
        end else begin
          icnt_s = icnt_r + IntervalWidth'(1'b1);
        end
      end
      ST_TRIG: begin
        state_s = ST_WAIT;
        wd_s    = '0;
      end
      ST_WAIT: begin
        // a step landing on the final watchdog cycle still counts as on time
        if (scrub_step_i) begin
          state_s = resume_s;
          wd_s    = '0;
        end else if (wd_r == WdWidth'(TimeoutCycles - 1)) begin
          state_s   = resume_s;
          wd_s      = '0;
          timeout_s = 1'b1;
        end else begin
          wd_s = wd_r + WdWidth'(1'b1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        icnt_s  = '0;
        wd_s    = '0;
      end
    endcase
  end

  // FSM registers; trigger is registered from the next-state decode
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      icnt_r  <= '0;
      wd_r    <= '0;
      trig_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      icnt_r  <= icnt_s;
      wd_r    <= wd_s;
      trig_r  <= (state_s == ST_TRIG);
    end
  end

  assign wrap_s = scrub_step_i && (addr_r == AddrWidth'(DataDepth - 1));

  // scrub address and pass-completion pulse, independent of FSM state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_r      <= '0;
      pass_done_r <= 1'b0;
    end else begin
      pass_done_r <= wrap_s;
      if (wrap_s) begin
        addr_r <= '0;
      end else if (scrub_step_i) begin
        addr_r <= addr_r + AddrWidth'(1'b1);
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  // sticky stall and interrupt flags; clear wins over a same-cycle set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_r <= 1'b0;
      irq_r   <= 1'b0;
    end else if (clear_i) begin
      stall_r <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      stall_r <= stall_r | timeout_s;
      irq_r   <= irq_r | (scrub_step_i & (tag_unc_i | data_unc_i));
    end
  end

  ecc_sat_counter #(.Width(CntWidth)) u_tag_corr_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc(scrub_step_i & tag_corr_i),
    .clr(clear_i), .cnt(tag_corr_cnt_o));
  ecc_sat_counter #(.Width(CntWidth)) u_tag_unc_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc(scrub_step_i & tag_unc_i),
    .clr(clear_i), .cnt(tag_unc_cnt_o));
  ecc_sat_counter #(.Width(CntWidth)) u_data_corr_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc(scrub_step_i & data_corr_i),
    .clr(clear_i), .cnt(data_corr_cnt_o));
  ecc_sat_counter #(.Width(CntWidth)) u_data_unc_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc(scrub_step_i & data_unc_i),
    .clr(clear_i), .cnt(data_unc_cnt_o));
  ecc_sat_counter #(.Width(CntWidth)) u_pass_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc(wrap_s),
    .clr(clear_i), .cnt(pass_cnt_o));

`ifdef ECC_SCRUB_ERR_ADDR_EN
  logic [AddrWidth-1:0] err_addr_r;
  logic                 err_valid_r;

  // latch the address of the first uncorrectable data error only
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_addr_r  <= '0;
      err_valid_r <= 1'b0;
    end else if (clear_i) begin
      err_addr_r  <= '0;
      err_valid_r <= 1'b0;
    end else if (scrub_step_i && data_unc_i && !err_valid_r) begin
      err_addr_r  <= addr_r;
      err_valid_r <= 1'b1;
    end else begin
      err_addr_r  <= err_addr_r;
      err_valid_r <= err_valid_r;
    end
  end

  assign err_addr_o       = err_addr_r;
  assign err_addr_valid_o = err_valid_r;
`endif

  assign scrub_trigger_o = trig_r;
  assign pass_done_o     = pass_done_r;
  assign cur_addr_o      = addr_r;
  assign stall_o         = stall_r;
  assign irq_o           = irq_r;

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// Randomized bench for ecc_scrub_scheduler against a cycle-schedule reference model.
module tb_ecc_scrub_scheduler;

  localparam int Depth = 8;
  localparam int AW    = 3;
  localparam int IW    = 8;
  localparam int CW    = 4;
  localparam int TO    = 64;
  localparam int MaxC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable = 1'b0;
  logic [IW-1:0] interval = '0;
  logic          clear = 1'b0;
  logic          scrub_trigger;
  logic          scrub_step = 1'b0;
  logic          tag_corr = 1'b0, tag_unc = 1'b0, data_corr = 1'b0, data_unc = 1'b0;
  logic [CW-1:0] tag_corr_cnt, tag_unc_cnt, data_corr_cnt, data_unc_cnt, pass_cnt;
  logic          pass_done;
  logic [AW-1:0] cur_addr;
  logic          stall, irq;
`ifdef ECC_SCRUB_ERR_ADDR_EN
  logic [AW-1:0] err_addr;
  logic          err_addr_valid;
`endif

  always #5 clk = ~clk;

  ecc_scrub_scheduler #(
    .DataDepth(Depth), .IntervalWidth(IW), .CntWidth(CW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .interval_i(interval),
    .clear_i(clear), .scrub_trigger_o(scrub_trigger), .scrub_step_i(scrub_step),
    .tag_corr_i(tag_corr), .tag_unc_i(tag_unc), .data_corr_i(data_corr), .data_unc_i(data_unc),
    .tag_corr_cnt_o(tag_corr_cnt), .tag_unc_cnt_o(tag_unc_cnt),
    .data_corr_cnt_o(data_corr_cnt), .data_unc_cnt_o(data_unc_cnt),
    .pass_cnt_o(pass_cnt), .pass_done_o(pass_done), .cur_addr_o(cur_addr),
    .stall_o(stall), .irq_o(irq)
`ifdef ECC_SCRUB_ERR_ADDR_EN
    , .err_addr_o(err_addr), .err_addr_valid_o(err_addr_valid)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: absolute cycle numbers of expected events plus plain counts
  int cyc = 0;
  int exp_trig = -1;
  int resp_cyc = -1;
  int to_cyc = -1;
  int interval_v = 0;
  bit enabled_m = 1'b0;
  bit awaiting = 1'b0;
  int e_addr = 0;
  int e_pass = 0;
  int e_cnt [4];
  bit e_pd = 1'b0, e_irq = 1'b0, e_stall = 1'b0;
  int e_err_addr = 0;
  bit e_err_v = 1'b0;

  int p_step = 0, p_flag = 0, p_clr = 0, resp_mode = 0;
  bit clr_on_step = 1'b0, en_drive = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check_val("trigger", 32'(scrub_trigger), 32'(enabled_m && (cyc == exp_trig)));
    check_val("cur_addr", 32'(cur_addr), 32'(e_addr));
    check_val("tag_corr_cnt", 32'(tag_corr_cnt), 32'(e_cnt[0]));
    check_val("tag_unc_cnt", 32'(tag_unc_cnt), 32'(e_cnt[1]));
    check_val("data_corr_cnt", 32'(data_corr_cnt), 32'(e_cnt[2]));
    check_val("data_unc_cnt", 32'(data_unc_cnt), 32'(e_cnt[3]));
    check_val("pass_cnt", 32'(pass_cnt), 32'(e_pass));
    check_val("pass_done", 32'(pass_done), 32'(e_pd));
    check_val("stall", 32'(stall), 32'(e_stall));
    check_val("irq", 32'(irq), 32'(e_irq));
`ifdef ECC_SCRUB_ERR_ADDR_EN
    check_val("err_addr", 32'(err_addr), 32'(e_err_addr));
    check_val("err_addr_valid", 32'(err_addr_valid), 32'(e_err_v));
`endif
  endtask

  task automatic model_zero();
    e_addr = 0; e_pass = 0; e_pd = 1'b0; e_irq = 1'b0; e_stall = 1'b0;
    e_err_addr = 0; e_err_v = 1'b0;
    for (int i = 0; i < 4; i++) e_cnt[i] = 0;
    enabled_m = 1'b0; awaiting = 1'b0; exp_trig = -1; resp_cyc = -1; to_cyc = -1;
  endtask

  task automatic do_reset(input int new_interval);
    rst_ni = 1'b0; enable = 1'b0; en_drive = 1'b0; clear = 1'b0; scrub_step = 1'b0;
    {tag_corr, tag_unc, data_corr, data_unc} = 4'b0000;
    interval_v = new_interval;
    interval = IW'(new_interval);
    model_zero();
    #2;
    check_outputs();
    @(posedge clk); #1; cyc++;
    rst_ni = 1'b1;
  endtask

  // one clock: compare, choose stimulus for this cycle, advance model to next cycle
  task automatic tick();
    bit stall_ev;
    bit [3:0] fl;
    bit step;
    check_outputs();
    stall_ev = 1'b0; step = 1'b0; fl = 4'b0000;
    enable = en_drive;
    if (en_drive && !enabled_m) begin
      enabled_m = 1'b1;
      exp_trig = cyc + interval_v + 2;
    end
    if (enabled_m && cyc == exp_trig) begin
      awaiting = 1'b1;
      to_cyc = cyc + TO;
      if (resp_mode == 1) resp_cyc = cyc + 2;
      else if (resp_mode == 2) resp_cyc = -1;
      else if ($urandom_range(99) < 4) resp_cyc = -1;
      else resp_cyc = cyc + int'($urandom_range(6, 1));
    end else if (awaiting) begin
      if (cyc == resp_cyc) begin
        step = 1'b1; awaiting = 1'b0; exp_trig = cyc + interval_v + 2;
      end else if (cyc == to_cyc) begin
        stall_ev = 1'b1; awaiting = 1'b0; exp_trig = cyc + interval_v + 2;
      end
    end else if (int'($urandom_range(99)) < p_step) begin
      step = 1'b1;
    end
    if (step) begin
      for (int i = 0; i < 4; i++) fl[i] = (int'($urandom_range(99)) < p_flag);
    end
    scrub_step = step;
    {data_unc, data_corr, tag_unc, tag_corr} = fl;
    clear = (int'($urandom_range(99)) < p_clr) || (clr_on_step && step);

    e_pd = 1'b0;
    if (step) begin
      if (fl[3] && !e_err_v) begin
        e_err_addr = e_addr; e_err_v = 1'b1;
      end
      for (int i = 0; i < 4; i++) if (fl[i] && e_cnt[i] < MaxC) e_cnt[i]++;
      if (fl[1] || fl[3]) e_irq = 1'b1;
      e_addr = (e_addr + 1) % Depth;
      if (e_addr == 0) begin
        e_pd = 1'b1;
        if (e_pass < MaxC) e_pass++;
      end
    end
    if (stall_ev) e_stall = 1'b1;
    if (clear) begin
      for (int i = 0; i < 4; i++) e_cnt[i] = 0;
      e_pass = 0; e_irq = 1'b0; e_stall = 1'b0; e_err_addr = 0; e_err_v = 1'b0;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) e_cnt[i] = 0;
    @(posedge clk); #1; cyc++;

    // fixed spacing: interval 3, step two cycles after each trigger, past a full pass
    do_reset(3);
    p_step = 0; p_flag = 0; p_clr = 0; resp_mode = 1; clr_on_step = 1'b0;
    run(3);
    en_drive = 1'b1;
    run(80);

    // randomized traffic with errors, clears and stray steps
    for (int k = 0; k < 4; k++) begin
      do_reset(int'($urandom_range(5, 0)));
      p_step = 10; p_flag = 30; p_clr = 3; resp_mode = 0;
      en_drive = 1'b1;
      run(400);
    end

    // watchdog: scrubber never answers
    do_reset(2);
    p_step = 0; p_flag = 0; p_clr = 0; resp_mode = 2;
    en_drive = 1'b1;
    run(220);

    // clear coincident with every step, then saturation of all counters
    do_reset(1);
    resp_mode = 0; p_step = 20; p_flag = 70; p_clr = 0; clr_on_step = 1'b1;
    en_drive = 1'b1;
    run(100);
    clr_on_step = 1'b0; p_step = 40; p_flag = 90;
    run(600);

    // reset while waiting for a step abandons it; no trigger until re-enabled
    resp_mode = 2; p_step = 0; p_flag = 0;
    for (int i = 0; i < 200 && !awaiting; i++) tick();
    check_val("reached_wait", 32'(awaiting), 32'd1);
    run(3);
    do_reset(2);
    resp_mode = 0;
    run(20);
    en_drive = 1'b1;
    run(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
